// File: rtl/memory_bank_be_if.sv
// rtl/memory_bank_be_if.sv - command/response bundle for memory_bank_be
// Purpose: groups the memory command inputs and read/status outputs.
// Signals: CS, A, D, BE, WE, RE, CLR (master -> slave); out, valid, busy (slave -> master).
interface memory_bank_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  CS;
  logic [ADDR_W-1:0]     A;
  logic [DATA_W-1:0]     D;
  logic [DATA_W/8-1:0]   BE;
  logic                  WE;
  logic                  RE;
  logic                  CLR;
  logic [DATA_W-1:0]     out;
  logic                  valid;
  logic                  busy;

  modport master (
    output CS, A, D, BE, WE, RE, CLR,
    input  out, valid, busy
  );

  modport slave (
    input  CS, A, D, BE, WE, RE, CLR,
    output out, valid, busy
  );
endinterface

// File: rtl/memory_bank_be.sv
// rtl/memory_bank_be.sv - single-port byte-enabled RAM with registered read and clear sequencer
// Purpose: word-addressed RAM, DEPTH = 2**ADDR_W words of DATA_W bits.
// Ports: CLK clock; R async active-low reset; bus (slave) carries
//   CS/A/D/BE/WE/RE/CLR commands and out/valid/busy responses.
module memory_bank_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic             CLK,
  input  logic             R,
  memory_bank_be_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  // CLR has top priority in IDLE and swallows any write/read in the same cycle.
  logic idle_cmd;
  logic wr_acc;
  logic rd_acc;

  always_comb begin
    idle_cmd = (state == ST_IDLE) && !bus.CLR && bus.CS;
    wr_acc   = idle_cmd && bus.WE;
    rd_acc   = idle_cmd && bus.RE;
  end

  // Array has no reset; the sweep zeroes it one word per cycle.
  always_ff @(posedge CLK) begin
    if (state == ST_CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.BE[i]) begin
          mem[bus.A][8*i +: 8] <= bus.D[8*i +: 8];
        end
      end
    end
  end

  // Read samples the pre-write word, giving read-before-write on WE+RE.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state     <= ST_CLEAR;
      cnt       <= '0;
      bus.busy  <= 1'b1;
      bus.out   <= '0;
      bus.valid <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          if (bus.CLR) begin
            state    <= ST_CLEAR;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end else if (rd_acc) begin
            bus.out   <= mem[bus.A];
            bus.valid <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_bank_be.sv
// tb/tb_memory_bank_be.sv - scoreboard bench for memory_bank_be
module tb_memory_bank_be;
  logic CLK = 1'b0;
  logic R   = 1'b0;

  memory_bank_be_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  memory_bank_be #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK (CLK),
    .R   (R),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];

  // Scoreboard consumer: every valid pulse must match the oldest expected read.
  always @(negedge CLK) begin
    if (R && bus.valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: out=%h with no read expected", bus.out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.out !== e) begin
          n_err++;
          $display("FAIL read_data: got %h expected %h", bus.out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    @(negedge CLK);
    bus.CS = 0; bus.WE = 0; bus.RE = 0; bus.CLR = 0;
    bus.A = '0; bus.D = '0; bus.BE = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be, input bit rd);
    @(negedge CLK);
    bus.CS = 1; bus.WE = 1; bus.RE = rd; bus.CLR = 0;
    bus.A = a; bus.D = d; bus.BE = be;
    if (rd) exp_q.push_back(model[a]);
    for (int i = 0; i < 4; i++)
      if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic rd(input logic [4:0] a);
    @(negedge CLK);
    bus.CS = 1; bus.WE = 0; bus.RE = 1; bus.CLR = 0;
    bus.A = a; bus.D = '0; bus.BE = '0;
    exp_q.push_back(model[a]);
  endtask

  // Counts rising edges until busy is seen low; bounded.
  task automatic sweep_len(output int n);
    bit done;
    n = 0; done = 0;
    while (!done && n < 100) begin
      @(posedge CLK); n++;
      @(negedge CLK);
      if (!bus.busy) done = 1;
    end
  endtask

  task automatic test_reset();
    int n;
    bus.CS = 0; bus.WE = 0; bus.RE = 0; bus.CLR = 0;
    bus.A = '0; bus.D = '0; bus.BE = '0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (bus.out !== 32'h0) begin n_err++; $display("FAIL reset_out: got %h expected 0", bus.out); end
    n_cmp++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b expected 1", bus.busy); end
    R = 1;
    sweep_len(n);
    n_cmp++; if (n !== 32) begin n_err++; $display("FAIL reset_sweep_len: got %0d expected 32", n); end
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rd(5'd0); rd(5'd17); rd(5'd31);
    idle(); idle();
  endtask

  task automatic test_byte_enable();
    wr(5'd3, 32'hAABBCCDD, 4'b1111, 0);
    wr(5'd3, 32'h11223344, 4'b0101, 0);
    wr(5'd4, 32'hDEADBEEF, 4'b0000, 0);
    rd(5'd3);
    idle();
    idle();
    n_cmp++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL be_valid_pulse: got %b expected 0", bus.valid); end
    rd(5'd4);
    idle(); idle();
  endtask

  task automatic test_read_before_write();
    wr(5'd7, 32'h12345678, 4'hF, 0);
    wr(5'd7, 32'hCAFEBABE, 4'hF, 1);
    rd(5'd7);
    idle(); idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 8; i < 16; i++) wr(i[4:0], $urandom, 4'hF, 0);
    for (int i = 8; i < 16; i++) rd(i[4:0]);
    idle(); idle();
  endtask

  task automatic test_cs_gating();
    wr(5'd2, 32'h0BADF00D, 4'hF, 0);
    @(negedge CLK);
    bus.CS = 0; bus.WE = 1; bus.RE = 0; bus.A = 5'd2; bus.D = 32'hFFFFFFFF; bus.BE = 4'hF;
    rd(5'd2);
    idle(); idle();
    @(negedge CLK);
    bus.CS = 0; bus.WE = 0; bus.RE = 1; bus.A = 5'd3;
    idle();
    n_cmp++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL cs_read_valid: got %b expected 0", bus.valid); end
    n_cmp++; if (bus.out !== 32'h0BADF00D) begin n_err++; $display("FAIL cs_read_hold: got %h expected 0badf00d", bus.out); end
  endtask

  task automatic test_clear();
    int n;
    bit done;
    for (int i = 0; i < 32; i++) wr(i[4:0], $urandom | 32'h1, 4'hF, 0);
    @(negedge CLK);
    bus.CS = 1; bus.WE = 1; bus.RE = 1; bus.CLR = 1; bus.A = 5'd0; bus.D = 32'h55AA55AA; bus.BE = 4'hF;
    idle();
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL clr_busy_rise: got %b expected 1", bus.busy); end
    n = 0; done = 0;
    while (!done && n < 100) begin
      bus.CS = 1; bus.WE = n[0]; bus.RE = ~n[0]; bus.CLR = n[1];
      bus.A = n[4:0]; bus.D = 32'hFFFFFFFF; bus.BE = 4'hF;
      @(posedge CLK); n++;
      @(negedge CLK);
      if (!bus.busy) done = 1;
    end
    bus.CS = 0; bus.WE = 0; bus.RE = 0; bus.CLR = 0;
    n_cmp++; if (n !== 32) begin n_err++; $display("FAIL clr_sweep_len: got %0d expected 32", n); end
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int i = 0; i < 32; i++) rd(i[4:0]);
    idle(); idle();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    wr(5'd9, 32'h5A5A5A5A, 4'hF, 0);
    rd(5'd9);
    @(negedge CLK);
    bus.CS = 0; bus.WE = 0; bus.RE = 0; bus.CLR = 1;
    idle();
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    #2 R = 0;
    #1;
    n_cmp++; if (bus.out !== 32'h0) begin n_err++; $display("FAIL rst_mid_out: got %h expected 0", bus.out); end
    n_cmp++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b expected 0", bus.valid); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 1", bus.busy); end
    @(negedge CLK);
    R = 1;
    sweep_len(n);
    n_cmp++; if (n !== 32) begin n_err++; $display("FAIL rst_mid_sweep_len: got %0d expected 32", n); end
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int i = 0; i < 32; i += 3) rd(i[4:0]);
    rd(5'd9);
    idle(); idle();
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_read_before_write();
    test_back_to_back();
    test_cs_gating();
    test_clear();
    test_reset_mid_sweep();
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_reads: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/memory_bank_be.md
# memory_bank_be

Parametrised successor to the fixed 8/32/128-byte memory blocks: a single-port, word-addressed RAM with configurable data width and depth, per-byte write enables and a registered read port with a `valid` flag. It also has a hardware clear sequencer that zeroes every word after reset or on command. It is the common storage primitive for all future lab datapaths, and replaces the fixed-size chained memories and their multiplexers.

## Interface
Parameters:
- `DATA_W`, 32: word width in bits; must be a multiple of 8, minimum 8.
- `ADDR_W`, 5: address width; depth `DEPTH = 2**ADDR_W` words.

Ports:
- `CLK`  in  1: single clock; all state changes on the rising edge.
- `R`  in  1: reset, asynchronous, active-low.
- `CS`  in  1: chip select; when 0, `WE`/`RE` are ignored.
- `A`  in  ADDR_W: word address.
- `D`  in  DATA_W: write data.
- `BE`  in  DATA_W/8: byte enables; bit i gates `D[8i+7:8i]`.
- `WE`  in  1: write enable.
- `RE`  in  1: read enable.
- `CLR`  in  1: request a full-memory clear (independent of `CS`).
- `out`  out  DATA_W: registered read data; holds its value between reads and is never Z.
- `valid`  out  1: one-cycle pulse marking new read data on `out`.
- `busy`  out  1: high while the clear sequence runs.

## Operation
- **FSM states**
  - IDLE: accepts commands.
  - CLEAR: sweeps a counter `cnt` (ADDR_W bits) over the memory and writes zero to word `cnt` every cycle.
- **Reset (`R`=0, asynchronous)**
  - Outputs forced: `out`=0, `valid`=0, `busy`=1.
  - FSM state forced to CLEAR, `cnt`=0.
  - Memory array contents are not reset directly; the sweep clears them.
- **CLEAR sweep**
  - Each edge writes 0 to word `cnt`, then increments `cnt`.
  - On the edge that writes word DEPTH-1: go to IDLE, `busy`←0, `cnt` wraps to 0.
- **Command decode in IDLE, priority order**
  1. `CLR`=1: go to CLEAR with `cnt`=0 and `busy`←1. Any `WE`/`RE` in the same cycle is dropped.
  2. `CS`=1, `WE`=1: bytes with `BE[i]`=1 are written; other bytes keep their contents. `BE`=0 is a no-op write.
  3. `CS`=1, `RE`=1: `out`←mem[A], `valid`←1.
- **Combined and ignored commands**
  - `WE` and `RE` may both be active in the same cycle. This is read-before-write: `out` returns the old word, and the new data is visible from the next read.
  - In CLEAR, `WE`, `RE` and `CLR` are all ignored and `valid` stays 0. A `CLR` arriving during a sweep does not restart it.
- **`valid` behaviour**: `valid` is 0 on every edge without an accepted read, so it is a single-cycle pulse per read.

## Timing
- **Read latency**: `RE` sampled at edge N gives `out`/`valid` updated at edge N; both are visible in the cycle after that edge. Back-to-back reads give one word per cycle.
- **Write**: takes effect at the sampling edge; a read sampled at the next edge returns the new data.
- **Sweep duration**: DEPTH edges after `R` deasserts or after the `CLR` edge. `busy` falls at the DEPTH-th edge, and the first command is accepted at edge DEPTH+1.
- **Reset mid-sweep**: the sweep restarts from word 0 after `R` deasserts.
- **Reset mid-read**: `out` and `valid` are cleared asynchronously.
- **Address range**: `A` is always in range, since DEPTH is a power of two. `cnt` wraps with no overflow flag.

## Test plan
- **Reset sweep**: release `R` with `ADDR_W`=5 and count cycles.
  - `busy`=1 for exactly 32 edges, then 0.
  - Reading addresses 0, 17 and 31 returns 0x00000000.
- **Byte-enable write**
  - Write 0xAABBCCDD to A=3 with `BE`=4'b1111, then 0x11223344 with `BE`=4'b0101.
  - A read of A=3 returns 0xAA22CC44 with `valid` high for exactly one cycle.
- **Read-before-write**
  - mem[7]=0x12345678. Drive `WE`=`RE`=1, A=7, D=0xCAFEBABE.
  - `out`=0x12345678; the next read returns 0xCAFEBABE.
- **`CS` gating and hold**
  - With `CS`=0, `WE`=1, D=0xFFFFFFFF to A=2: mem[2] is unchanged.
  - With `CS`=0, `RE`=1: `valid`=0 and `out` holds its previous value.
- **Clear command with a concurrent write**
  - Fill memory, then assert `CLR` together with `WE` to A=0.
  - `busy` is high for 32 cycles. `WE`/`RE`/`CLR` pulses during the sweep are ignored.
  - All words read back as 0 afterwards.
- **Reset mid-sweep**
  - Pulse `R` low at sweep cycle 10.
  - `out`=0 and `valid`=0 immediately. A full 32-cycle sweep follows the release, and all words are 0.
